// File: rtl/level_histogram_classifier.sv
// ---------------------------------------------------------------------------
// level_histogram_classifier
//
// Builds a loudness histogram of signed audio samples over a fixed window. The
// block then reports which bin dominated that window. It is the parametrised
// successor of the fixed 10-bin loudness counter. It sits between the audio
// controller's left-channel output and the display/decibel logic.
//
// Pipeline:
//   S1    : register |sample| (saturated) together with its valid strobe
//   S2    : classify the magnitude against the runtime bin edges and bump the
//           matching live bin; advance the window counter
//   SNAP  : at window end the live bins (including the S2 increment of that
//           same edge) are copied to a shadow bank and the live bins restart
//   SCAN  : one shadow bin per cycle; finds the modal bin and the highest
//           non-empty bin, then publishes the result one edge later
//
// Ports:
//   clock         in   1                      system clock
//   reset_n       in   1                      asynchronous active-low reset
//   sample        in   SAMPLE_W               signed two's-complement sample
//   sample_valid  in   1                      sample qualifier (used only when enable=1)
//   enable        in   1                      counting enable
//   clear         in   1                      sync clear of live bins, window counter and scan
//   thresh        in   (NUM_BINS-1)*SAMPLE_W  ascending unsigned bin edges, T0 in the LSBs
//   level_idx     out  IDX_W                  dominant bin of the last window
//   peak_idx      out  IDX_W                  highest non-empty bin of the last window
//   window_empty  out  1                      last window held no samples
//   level_valid   out  1                      one-cycle pulse, results change with it
//   overrun       out  1                      sticky: a window closed while a scan was running
// ---------------------------------------------------------------------------
module level_histogram_classifier #(
    parameter int SAMPLE_W   = 32,
    parameter int NUM_BINS   = 10,
    parameter int WINDOW     = 25000000,
    parameter int CNT_W      = 25,
    parameter int IDX_W      = 4,
    parameter int COUNT_MODE = 0
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic signed [SAMPLE_W-1:0]         sample,
    input  logic                               sample_valid,
    input  logic                               enable,
    input  logic                               clear,
    input  logic [(NUM_BINS-1)*SAMPLE_W-1:0]   thresh,
    output logic [IDX_W-1:0]                   level_idx,
    output logic [IDX_W-1:0]                   peak_idx,
    output logic                               window_empty,
    output logic                               level_valid,
    output logic                               overrun
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_SCAN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BINS - 1);

    // Absolute value; the most-negative code has no positive twin, so it is
    // clamped to the largest positive magnitude.
    function automatic logic [SAMPLE_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] s);
        logic signed [SAMPLE_W-1:0] most_neg;
        most_neg = {1'b1, {(SAMPLE_W-1){1'b0}}};
        if (s == most_neg) begin
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (s[SAMPLE_W-1]) begin
            return -s;
        end else begin
            return s;
        end
    endfunction

    // Bin counters stick at full scale instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

    // Stage S1 registers
    logic [SAMPLE_W-1:0] mag_p1_q;
    logic                vld_p1_q;

    // Stage S2 / window signals
    logic [IDX_W-1:0]    bin_p1;
    logic                inc_p1;
    logic                win_evt;
    logic                snapshot;
    logic [CNT_W-1:0]    win_q, win_d;

    logic [CNT_W-1:0]    live_q   [NUM_BINS];
    logic [CNT_W-1:0]    live_d   [NUM_BINS];
    logic [CNT_W-1:0]    live_inc [NUM_BINS];
    logic [CNT_W-1:0]    shadow_q [NUM_BINS];
    logic [CNT_W-1:0]    shadow_d [NUM_BINS];

    // Scan / result state
    state_t              state_q, state_d;
    logic [IDX_W-1:0]    scan_q, scan_d;
    logic [CNT_W-1:0]    scan_cnt;
    logic [CNT_W-1:0]    best_cnt_q, best_cnt_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic [IDX_W-1:0]    peak_q, peak_d;
    logic                any_q, any_d;
    logic                done_q, done_d;
    logic [IDX_W-1:0]    level_idx_q, level_idx_d;
    logic [IDX_W-1:0]    peak_idx_q, peak_idx_d;
    logic                empty_q, empty_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    // ---- S1: magnitude and qualified valid --------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mag_p1_q <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            mag_p1_q <= abs_sat(sample);
            vld_p1_q <= sample_valid & enable;
        end
    end

    // ---- S2: classification, live bins, window counter --------------------
    // Edges are ascending, so the last edge that the magnitude reaches
    // selects the bin. A magnitude below T0 stays in bin 0.
    always_comb begin
        bin_p1 = '0;
        for (int k = 0; k < NUM_BINS - 1; k++) begin
            if (mag_p1_q >= thresh[k*SAMPLE_W +: SAMPLE_W]) begin
                bin_p1 = IDX_W'(k + 1);
            end
        end
    end

    assign inc_p1   = vld_p1_q & ~clear;
    assign win_evt  = (COUNT_MODE == 0) ? enable : inc_p1;
    assign snapshot = ~clear & win_evt & (win_q == WIN_LAST);

    always_comb begin
        win_d = win_q;
        if (clear || snapshot) begin
            win_d = '0;
        end else if (win_evt) begin
            win_d = win_q + 1'b1;
        end
    end

    // The shadow bank takes the post-increment value. A sample that lands on
    // the closing edge is therefore counted in the window it closes.
    always_comb begin
        for (int i = 0; i < NUM_BINS; i++) begin
            live_inc[i] = (inc_p1 && (bin_p1 == IDX_W'(i))) ? sat_inc(live_q[i]) : live_q[i];
            live_d[i]   = (clear || snapshot) ? '0 : live_inc[i];
            shadow_d[i] = snapshot ? live_inc[i] : shadow_q[i];
        end
    end

    // ---- SCAN: background search over the shadow bank ---------------------
    always_comb begin
        scan_cnt = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (scan_q == IDX_W'(i)) begin
                scan_cnt = shadow_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        scan_d      = scan_q;
        best_cnt_d  = best_cnt_q;
        best_idx_d  = best_idx_q;
        peak_d      = peak_q;
        any_d       = any_q;
        done_d      = 1'b0;
        level_idx_d = level_idx_q;
        peak_idx_d  = peak_idx_q;
        empty_d     = empty_q;
        valid_d     = 1'b0;
        overrun_d   = overrun_q;

        // A finished scan publishes one edge after its last bin. This can
        // coincide with the next snapshot, which uses the already-cleared
        // state below.
        if (done_q && !clear) begin
            level_idx_d = best_idx_q;
            peak_idx_d  = peak_q;
            empty_d     = ~any_q;
            valid_d     = 1'b1;
        end

        if (clear) begin
            state_d = ST_ACCUM;
            scan_d  = '0;
        end else if (snapshot) begin
            // Restarting discards whatever the running scan had gathered.
            if (state_q == ST_SCAN) begin
                overrun_d = 1'b1;
            end
            state_d    = ST_SCAN;
            scan_d     = '0;
            best_cnt_d = '0;
            best_idx_d = '0;
            peak_d     = '0;
            any_d      = 1'b0;
        end else if (state_q == ST_SCAN) begin
            // Strictly-greater keeps the lowest index on ties.
            if (scan_cnt > best_cnt_q) begin
                best_cnt_d = scan_cnt;
                best_idx_d = scan_q;
            end
            if (scan_cnt != '0) begin
                peak_d = scan_q;
                any_d  = 1'b1;
            end
            if (scan_q == IDX_LAST) begin
                state_d = ST_ACCUM;
                done_d  = 1'b1;
            end else begin
                scan_d = scan_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            win_q       <= '0;
            for (int i = 0; i < NUM_BINS; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
            state_q     <= ST_ACCUM;
            scan_q      <= '0;
            best_cnt_q  <= '0;
            best_idx_q  <= '0;
            peak_q      <= '0;
            any_q       <= 1'b0;
            done_q      <= 1'b0;
            level_idx_q <= '0;
            peak_idx_q  <= '0;
            empty_q     <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            win_q       <= win_d;
            for (int i = 0; i < NUM_BINS; i++) begin
                live_q[i]   <= live_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            state_q     <= state_d;
            scan_q      <= scan_d;
            best_cnt_q  <= best_cnt_d;
            best_idx_q  <= best_idx_d;
            peak_q      <= peak_d;
            any_q       <= any_d;
            done_q      <= done_d;
            level_idx_q <= level_idx_d;
            peak_idx_q  <= peak_idx_d;
            empty_q     <= empty_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign level_idx    = level_idx_q;
    assign peak_idx     = peak_idx_q;
    assign window_empty = empty_q;
    assign level_valid  = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_level_histogram_classifier.sv
// Bench for level_histogram_classifier. Three instances share one stimulus:
//   d0: COUNT_MODE=1, WINDOW=8   d1: COUNT_MODE=0, WINDOW=16   d2: COUNT_MODE=1, WINDOW=4
// All three use NUM_BINS=4 and bin edges {100,200,300}. A window-level reference
// model predicts the outputs of every instance after every clock edge.
module tb_level_histogram_classifier;

    localparam int SW = 32;
    localparam int NB = 4;
    localparam int CW = 8;
    localparam int IW = 4;
    localparam int ND = 3;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic signed [SW-1:0]   sample;
    logic                   sample_valid;
    logic                   enable;
    logic                   clear;
    logic [(NB-1)*SW-1:0]   thresh;
    logic [IW-1:0]          lvl_o [ND];
    logic [IW-1:0]          pk_o  [ND];
    logic                   emp_o [ND];
    logic                   lv_o  [ND];
    logic                   ovr_o [ND];

    always #5 clock = ~clock;

    level_histogram_classifier #(.SAMPLE_W(SW), .NUM_BINS(NB), .WINDOW(8), .CNT_W(CW),
                                 .IDX_W(IW), .COUNT_MODE(1)) u_d0 (
        .clock(clock), .reset_n(reset_n), .sample(sample), .sample_valid(sample_valid),
        .enable(enable), .clear(clear), .thresh(thresh), .level_idx(lvl_o[0]),
        .peak_idx(pk_o[0]), .window_empty(emp_o[0]), .level_valid(lv_o[0]), .overrun(ovr_o[0]));

    level_histogram_classifier #(.SAMPLE_W(SW), .NUM_BINS(NB), .WINDOW(16), .CNT_W(CW),
                                 .IDX_W(IW), .COUNT_MODE(0)) u_d1 (
        .clock(clock), .reset_n(reset_n), .sample(sample), .sample_valid(sample_valid),
        .enable(enable), .clear(clear), .thresh(thresh), .level_idx(lvl_o[1]),
        .peak_idx(pk_o[1]), .window_empty(emp_o[1]), .level_valid(lv_o[1]), .overrun(ovr_o[1]));

    level_histogram_classifier #(.SAMPLE_W(SW), .NUM_BINS(NB), .WINDOW(4), .CNT_W(CW),
                                 .IDX_W(IW), .COUNT_MODE(1)) u_d2 (
        .clock(clock), .reset_n(reset_n), .sample(sample), .sample_valid(sample_valid),
        .enable(enable), .clear(clear), .thresh(thresh), .level_idx(lvl_o[2]),
        .peak_idx(pk_o[2]), .window_empty(emp_o[2]), .level_valid(lv_o[2]), .overrun(ovr_o[2]));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    int      edges_thr [NB-1] = '{100, 200, 300};
    bit      m_s1v;
    longint  m_s1mag;
    int      m_cnt  [ND];
    int      m_hist [ND][NB];
    bit      m_pend [ND];
    int      m_snap [ND];
    int      m_plvl [ND];
    int      m_ppk  [ND];
    bit      m_pemp [ND];
    int      e_lvl  [ND];
    int      e_pk   [ND];
    bit      e_emp  [ND];
    bit      e_lv   [ND];
    bit      e_ovr  [ND];
    int      now;

    // DUT-observed bookkeeping for directed scenario checks
    int      last_lvl0, last_pk0, n_lv0, n_lv1;

    function automatic int win_of(input int d);
        return (d == 0) ? 8 : (d == 1) ? 16 : 4;
    endfunction

    function automatic bit counts_samples(input int d);
        return d != 1;
    endfunction

    function automatic longint abs_mag(input logic signed [SW-1:0] s);
        longint v;
        v = s;
        if (v == -(longint'(1) << 31)) return (longint'(1) << 31) - 1;
        return (v < 0) ? -v : v;
    endfunction

    // The bin number is the count of bin edges at or below the magnitude.
    function automatic int bin_of(input longint m);
        int b;
        b = 0;
        for (int k = 0; k < NB - 1; k++) if (m >= edges_thr[k]) b++;
        return b;
    endfunction

    task automatic model_reset();
        m_s1v = 0;
        m_s1mag = 0;
        now = 0;
        for (int d = 0; d < ND; d++) begin
            m_cnt[d] = 0;
            for (int b = 0; b < NB; b++) m_hist[d][b] = 0;
            m_pend[d] = 0; m_snap[d] = 0;
            m_plvl[d] = 0; m_ppk[d] = 0; m_pemp[d] = 0;
            e_lvl[d] = 0; e_pk[d] = 0; e_emp[d] = 0; e_lv[d] = 0; e_ovr[d] = 0;
        end
    endtask

    task automatic take_snapshot(input int d);
        int total, mx, lvl, pk;
        total = 0; mx = 0; lvl = 0; pk = 0;
        for (int b = 0; b < NB; b++) begin
            total += m_hist[d][b];
            if (m_hist[d][b] > mx) mx = m_hist[d][b];
        end
        for (int b = NB - 1; b >= 0; b--) if (mx > 0 && m_hist[d][b] == mx) lvl = b;
        for (int b = 0; b < NB; b++) if (m_hist[d][b] != 0) pk = b;
        // A window that closes before the previous result is out is an overrun.
        if (m_pend[d]) e_ovr[d] = 1;
        m_pend[d] = 1;
        m_snap[d] = now;
        m_plvl[d] = lvl;
        m_ppk[d]  = pk;
        m_pemp[d] = (total == 0);
        for (int b = 0; b < NB; b++) m_hist[d][b] = 0;
    endtask

    task automatic model_edge();
        bit ev;
        for (int d = 0; d < ND; d++) begin
            e_lv[d] = 0;
            if (clear) begin
                m_cnt[d] = 0;
                for (int b = 0; b < NB; b++) m_hist[d][b] = 0;
                m_pend[d] = 0;
            end else begin
                if (m_pend[d] && now == m_snap[d] + NB + 1) begin
                    e_lvl[d] = m_plvl[d];
                    e_pk[d]  = m_ppk[d];
                    e_emp[d] = m_pemp[d];
                    e_lv[d]  = 1;
                    m_pend[d] = 0;
                end
                if (m_s1v) m_hist[d][bin_of(m_s1mag)]++;
                ev = counts_samples(d) ? m_s1v : enable;
                if (ev) begin
                    m_cnt[d]++;
                    if (m_cnt[d] == win_of(d)) begin
                        m_cnt[d] = 0;
                        take_snapshot(d);
                    end
                end
            end
        end
        m_s1v   = sample_valid & enable;
        m_s1mag = abs_mag(sample);
        now++;
    endtask

    task automatic check_all();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d_level_valid", d), lv_o[d], e_lv[d]);
            chk($sformatf("d%0d_level_idx", d), lvl_o[d], e_lvl[d]);
            chk($sformatf("d%0d_peak_idx", d), pk_o[d], e_pk[d]);
            chk($sformatf("d%0d_window_empty", d), emp_o[d], e_emp[d]);
            chk($sformatf("d%0d_overrun", d), ovr_o[d], e_ovr[d]);
        end
        if (lv_o[0]) begin
            last_lvl0 = lvl_o[0];
            last_pk0  = pk_o[0];
            n_lv0++;
        end
        if (lv_o[1]) n_lv1++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic drive(input bit v, input logic signed [SW-1:0] s, input bit en, input bit clr);
        sample_valid = v;
        sample       = s;
        enable       = en;
        clear        = clr;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, '0, 0, 0);
        #2;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset_n = 1'b1;
    endtask

    function automatic logic signed [SW-1:0] rnd_sample();
        int sel;
        int base;
        logic signed [SW-1:0] v;
        sel = $urandom_range(0, 9);
        if (sel == 0) begin
            v = 32'sh8000_0000;
        end else if (sel == 1) begin
            v = $urandom;
        end else begin
            if (sel <= 6) base = 100 * $urandom_range(1, 3) + $urandom_range(0, 4) - 2;
            else          base = $urandom_range(0, 450);
            v = base;
            if ($urandom_range(0, 1) == 1) v = -v;
        end
        return v;
    endfunction

    logic signed [SW-1:0] s2_vec [8];
    int pulses;

    initial begin
        thresh  = {32'd300, 32'd200, 32'd100};
        reset_n = 1'b1;
        drive(0, '0, 0, 0);
        last_lvl0 = 0; last_pk0 = 0; n_lv0 = 0; n_lv1 = 0;
        model_reset();
        #1;
        do_reset();

        // Reset in the middle of a window after five samples
        for (int i = 0; i < 5; i++) begin
            drive(1, rnd_sample(), 1, 0);
            tick();
        end
        do_reset();

        // Mixed magnitudes around every bin edge, including the most-negative code
        s2_vec = '{32'sd99, 32'sd100, -32'sd199, 32'sd200, 32'sd299, 32'sd300,
                   32'sh8000_0000, -32'sd300};
        for (int i = 0; i < 8; i++) begin
            drive(1, s2_vec[i], 1, 0);
            tick();
        end
        drive(0, '0, 1, 0);
        for (int i = 0; i < 8; i++) tick();
        chk("s2_level_idx", last_lvl0, 3);
        chk("s2_peak_idx", last_pk0, 3);

        // Tie between bin 1 and bin 2 resolves to the lower bin
        for (int i = 0; i < 8; i++) begin
            drive(1, (i < 4) ? 32'sd150 : 32'sd250, 1, 0);
            tick();
        end
        drive(0, '0, 1, 0);
        for (int i = 0; i < 8; i++) tick();
        chk("s3_level_idx", last_lvl0, 1);
        chk("s3_peak_idx", last_pk0, 2);

        // Enabled but silent: the cycle-counting instance reports empty windows
        pulses = n_lv1;
        for (int i = 0; i < 48; i++) tick();
        chk("s4_pulses", n_lv1 - pulses, 3);
        chk("s4_empty", emp_o[1], 1);
        chk("s4_level_idx", lvl_o[1], 0);

        // Back-to-back windows with continuous samples
        for (int i = 0; i < 20; i++) begin
            drive(1, rnd_sample(), 1, 0);
            tick();
        end
        drive(0, '0, 1, 0);
        for (int i = 0; i < 8; i++) tick();
        chk("s5_no_overrun_d0", ovr_o[0], 0);
        chk("s6_overrun_d2", ovr_o[2], 1);

        // clear while d0 is scanning suppresses that result
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'sd250, 1, 0);
            tick();
        end
        drive(0, '0, 1, 0);
        tick();
        tick();
        pulses = n_lv0;
        drive(0, '0, 1, 1);
        tick();
        drive(0, '0, 1, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("s6_clear_no_pulse", n_lv0 - pulses, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            drive(($urandom_range(0, 3) != 0), rnd_sample(),
                  ($urandom_range(0, 15) != 0), ($urandom_range(0, 63) == 0));
            tick();
        end
        drive(0, '0, 0, 0);
        for (int i = 0; i < 8; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
